// File: rtl/fifo_pwr_quarter_reader.sv
// Read-side stage of the 8->4 width-converting video FIFO: drains fixed-length lines of
// nibbles onto a pix_data/pix_de bus with HBLANK gaps. Optional macro UNDERRUN_CNT_EN adds underrun_cnt.
module fifo_pwr_quarter_reader #(
    parameter int unsigned LINE_NIBBLES = 16,
    parameter int unsigned HBLANK       = 4,
    parameter logic [3:0]  IDLE_NIBBLE  = 4'h0
) (
    input  logic        readclk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear_err,
    input  logic [3:0]  fifo_dout,
    input  logic        fifo_empty,
    input  logic        fifo_almostempty,
    output logic        fifo_readen,
    output logic [3:0]  pix_data,
    output logic        pix_de,
    output logic        line_done,
    output logic        underrun
`ifdef UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        ACTIVE,
        GAP
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(LINE_NIBBLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(HBLANK - 1);

    state_t      state;
    logic [15:0] rd_cnt;
    logic [15:0] gap_cnt;
    logic        rd_q;
    logic        last_q;
    logic        read_last;
    logic        starve;

    // A starved ACTIVE cycle is a bubble: no read, and rd_cnt holds so the line still gets every nibble.
    assign fifo_readen = (state == ACTIVE) && !fifo_empty;
    assign starve      = (state == ACTIVE) && fifo_empty;
    assign read_last   = fifo_readen && (rd_cnt == LAST_IDX);

    always_ff @(posedge readclk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rd_cnt  <= 16'd0;
            gap_cnt <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= PRIME;
                    end
                end
                PRIME: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (!fifo_almostempty && !fifo_empty) begin
                        state  <= ACTIVE;
                        rd_cnt <= 16'd0;
                    end
                end
                ACTIVE: begin
                    if (fifo_readen) begin
                        rd_cnt <= rd_cnt + 16'd1;
                        if (read_last) begin
                            state   <= GAP;
                            gap_cnt <= 16'd0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= enable ? PRIME : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // fifo_dout is valid the cycle after an accepted read, so rd_q aligns the strobe with the data.
    always_ff @(posedge readclk or posedge reset) begin
        if (reset) begin
            rd_q      <= 1'b0;
            last_q    <= 1'b0;
            pix_de    <= 1'b0;
            pix_data  <= IDLE_NIBBLE;
            line_done <= 1'b0;
        end else begin
            rd_q      <= fifo_readen;
            last_q    <= read_last;
            pix_de    <= rd_q;
            pix_data  <= rd_q ? fifo_dout : IDLE_NIBBLE;
            line_done <= rd_q && last_q;
        end
    end

    always_ff @(posedge readclk or posedge reset) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (starve) begin
            underrun <= 1'b1;
        end else if (clear_err) begin
            underrun <= 1'b0;
        end
    end

`ifdef UNDERRUN_CNT_EN
    // A starve coinciding with clear_err restarts the count at one rather than zero.
    always_ff @(posedge readclk or posedge reset) begin
        if (reset) begin
            underrun_cnt <= 16'd0;
        end else if (starve) begin
            if (clear_err) begin
                underrun_cnt <= 16'd1;
            end else if (underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end else if (clear_err) begin
            underrun_cnt <= 16'd0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_pwr_quarter_reader.sv
// Directed bench for fifo_pwr_quarter_reader (LINE_NIBBLES=16, HBLANK=4) with a small FIFO model.
// Define UNDERRUN_CNT_EN to also exercise the underrun counter.
module tb_fifo_pwr_quarter_reader;

    logic        readclk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear_err = 1'b0;
    logic [3:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_almostempty;
    logic        fifo_readen;
    logic [3:0]  pix_data;
    logic        pix_de;
    logic        line_done;
    logic        underrun;
`ifdef UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       force_empty = 1'b0;
    logic       force_ae = 1'b0;

    logic       rdl [0:127];
    logic       del [0:127];
    logic       ldl [0:127];
    logic       url [0:127];
    logic [3:0] dal [0:127];
    int         n = 0;

    int          rd_count, de_count, done_count, first_de, sixteenth_de, first_done, idle_bad, ur_count;
    logic [63:0] line_data;

    fifo_pwr_quarter_reader #(
        .LINE_NIBBLES(16),
        .HBLANK(4),
        .IDLE_NIBBLE(4'h0)
    ) dut (
        .readclk(readclk),
        .reset(reset),
        .enable(enable),
        .clear_err(clear_err),
        .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_almostempty(fifo_almostempty),
        .fifo_readen(fifo_readen),
        .pix_data(pix_data),
        .pix_de(pix_de),
        .line_done(line_done),
        .underrun(underrun)
`ifdef UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 readclk = ~readclk;

    // FIFO model: data appears on fifo_dout one clock after an accepted read.
    always @(posedge readclk) begin
        if (fifo_readen) begin
            fifo_dout <= mem[rd_ptr % 256];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    assign fifo_empty       = force_empty || (wr_ptr == rd_ptr);
    assign fifo_almostempty = force_ae || ((wr_ptr - rd_ptr) < 4);

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic push_nibbles(input int count, input int start);
        for (int i = 0; i < count; i++) begin
            mem[wr_ptr % 256] = 4'((start + i) % 16);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    // Logs one cycle at its falling edge, then returns just after the next rising edge
    // so that any input change applies to the following cycle.
    task automatic applyStimulus();
        @(negedge readclk);
        if (n < 128) begin
            rdl[n] = fifo_readen;
            del[n] = pix_de;
            ldl[n] = line_done;
            url[n] = underrun;
            dal[n] = pix_data;
        end
        n = n + 1;
        @(posedge readclk);
        #1;
    endtask

    task automatic analyze_log(input int lo, input int hi);
        rd_count = 0; de_count = 0; done_count = 0; idle_bad = 0; ur_count = 0;
        first_de = -1; sixteenth_de = -1; first_done = -1; line_data = 64'd0;
        for (int i = lo; i < hi && i < 128; i++) begin
            if (rdl[i]) rd_count++;
            if (del[i]) begin
                if (de_count == 0) first_de = i;
                if (de_count < 16) line_data = {line_data[59:0], dal[i]};
                de_count++;
                if (de_count == 16) sixteenth_de = i;
            end else if (dal[i] != 4'h0) begin
                idle_bad++;
            end
            if (ldl[i]) begin
                if (done_count == 0) first_done = i;
                done_count++;
            end
            if (url[i]) ur_count++;
        end
    endtask

    initial begin
        // Reset state with enable high and a full FIFO
        enable = 1'b1;
        push_nibbles(40, 0);
        @(negedge readclk);
        checkOutput("rst_readen", 64'(fifo_readen), 64'd0);
        checkOutput("rst_pix_data", 64'(pix_data), 64'h0);
        checkOutput("rst_pix_de", 64'(pix_de), 64'd0);
        checkOutput("rst_line_done", 64'(line_done), 64'd0);
        checkOutput("rst_underrun", 64'(underrun), 64'd0);
`ifdef UNDERRUN_CNT_EN
        checkOutput("rst_underrun_cnt", 64'(underrun_cnt), 64'd0);
`endif
        @(posedge readclk);
        #1;
        reset = 1'b0;
        n = 0;

        // Two lines back to back; enable drops after the 5th read of line 2
        repeat (28) applyStimulus();
        enable = 1'b0;
        repeat (36) applyStimulus();
        checkOutput("a_idle_cycle", 64'(rdl[0]), 64'd0);
        checkOutput("a_prime_cycle", 64'(rdl[1]), 64'd0);
        checkOutput("a_first_read", 64'(rdl[2]), 64'd1);
        analyze_log(2, 18);
        checkOutput("a_line1_reads", 64'(rd_count), 64'd16);
        analyze_log(18, 23);
        checkOutput("a_gap_prime_low", 64'(rd_count), 64'd0);
        checkOutput("a_line2_start", 64'(rdl[23]), 64'd1);
        analyze_log(0, 23);
        checkOutput("a_line1_de", 64'(de_count), 64'd16);
        checkOutput("a_line1_data", line_data, 64'h0123456789ABCDEF);
        checkOutput("a_line1_contig", 64'(sixteenth_de - first_de), 64'd15);
        checkOutput("a_line1_first_de", 64'(first_de), 64'd4);
        checkOutput("a_line1_done_pos", 64'(first_done), 64'(sixteenth_de));
        analyze_log(23, 64);
        checkOutput("a_line2_data", line_data, 64'h0123456789ABCDEF);
        checkOutput("a_line2_de", 64'(de_count), 64'd16);
        checkOutput("a_line2_done_cnt", 64'(done_count), 64'd1);
        checkOutput("a_line2_done_pos", 64'(first_done), 64'(sixteenth_de));
        analyze_log(39, 64);
        checkOutput("a_idle_no_read", 64'(rd_count), 64'd0);
        checkOutput("a_fifo_left", 64'(wr_ptr - rd_ptr), 64'd8);
        analyze_log(0, 64);
        checkOutput("a_idle_data", 64'(idle_bad), 64'd0);
        checkOutput("a_no_underrun", 64'(ur_count), 64'd0);

        // Three starved cycles after the 5th read
        reset = 1'b1;
        wr_ptr = rd_ptr;
        push_nibbles(20, 0);
        enable = 1'b1;
        @(posedge readclk);
        #1;
        reset = 1'b0;
        n = 0;
        repeat (7) applyStimulus();
        force_empty = 1'b1;
        repeat (3) applyStimulus();
        force_empty = 1'b0;
        enable = 1'b0;
        repeat (35) applyStimulus();
        analyze_log(7, 10);
        checkOutput("b_bubble_reads", 64'(rd_count), 64'd0);
        analyze_log(0, 45);
        checkOutput("b_total_reads", 64'(rd_count), 64'd16);
        checkOutput("b_total_de", 64'(de_count), 64'd16);
        checkOutput("b_data", line_data, 64'h0123456789ABCDEF);
        checkOutput("b_de_span", 64'(sixteenth_de - first_de), 64'd18);
        checkOutput("b_done_pos", 64'(first_done), 64'(sixteenth_de));
        checkOutput("b_idle_data", 64'(idle_bad), 64'd0);
        checkOutput("b_ur_before", 64'(url[7]), 64'd0);
        checkOutput("b_ur_set", 64'(url[8]), 64'd1);
        checkOutput("b_ur_sticky", 64'(url[44]), 64'd1);
`ifdef UNDERRUN_CNT_EN
        checkOutput("b_underrun_cnt", 64'(underrun_cnt), 64'd3);
`endif

        // clear_err in the same cycle as a new underrun, then a lone clear_err
        n = 0;
        push_nibbles(16, 0);
        enable = 1'b1;
        repeat (3) applyStimulus();
        force_empty = 1'b1;
        clear_err = 1'b1;
        applyStimulus();
        force_empty = 1'b0;
        clear_err = 1'b0;
        enable = 1'b0;
        applyStimulus();
        checkOutput("d_set_wins", 64'(underrun), 64'd1);
`ifdef UNDERRUN_CNT_EN
        checkOutput("d_cnt_restart", 64'(underrun_cnt), 64'd1);
`endif
        repeat (30) applyStimulus();
        analyze_log(0, 35);
        checkOutput("d_reads", 64'(rd_count), 64'd16);
        checkOutput("d_data", line_data, 64'h01230123456789AB);
        checkOutput("d_ur_held", 64'(url[34]), 64'd1);
        clear_err = 1'b1;
        applyStimulus();
        clear_err = 1'b0;
        applyStimulus();
        checkOutput("d_lone_clear", 64'(underrun), 64'd0);
`ifdef UNDERRUN_CNT_EN
        checkOutput("d_cnt_clear", 64'(underrun_cnt), 64'd0);
`endif

        // Asynchronous reset in the middle of a line
        wr_ptr = rd_ptr;
        push_nibbles(40, 0);
        enable = 1'b1;
        n = 0;
        repeat (8) applyStimulus();
        checkOutput("e_pre_de", 64'(pix_de), 64'd1);
        checkOutput("e_pre_readen", 64'(fifo_readen), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("e_async_readen", 64'(fifo_readen), 64'd0);
        checkOutput("e_async_de", 64'(pix_de), 64'd0);
        checkOutput("e_async_done", 64'(line_done), 64'd0);
        checkOutput("e_async_data", 64'(pix_data), 64'h0);
        @(posedge readclk);
        #1;
        reset = 1'b0;
        force_ae = 1'b1;
        n = 0;
        repeat (8) applyStimulus();
        force_ae = 1'b0;
        repeat (4) applyStimulus();
        enable = 1'b0;
        repeat (33) applyStimulus();
        analyze_log(0, 8);
        checkOutput("e_prime_hold", 64'(rd_count), 64'd0);
        checkOutput("e_ae_last_wait", 64'(rdl[8]), 64'd0);
        checkOutput("e_first_read", 64'(rdl[9]), 64'd1);
        analyze_log(0, 45);
        checkOutput("e_reads", 64'(rd_count), 64'd16);
        checkOutput("e_de", 64'(de_count), 64'd16);
        checkOutput("e_data", line_data, 64'h6789ABCDEF012345);
        checkOutput("e_contig", 64'(sixteenth_de - first_de), 64'd15);
        checkOutput("e_done_pos", 64'(first_done), 64'(sixteenth_de));
        checkOutput("e_done_cnt", 64'(done_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
